// File: rtl/rv_pkg.sv
// rv_pkg: shared widths and the write-back entry type
package rv_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO of write-back entries buffering load returns
import rv_pkg::*;
module rf_wb_fifo #(
    parameter int FifoDepth = 4
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  wb_entry_t                  din,
    output wb_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(FifoDepth):0] count
);
    localparam int PW = $clog2(FifoDepth);
    localparam int CW = PW + 1;
    wb_entry_t mem [FifoDepth];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == CW'(FifoDepth);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    always_ff @(posedge Clk)
        if (do_push) mem[wr_ptr] <= din;
    // Power-of-two depth: pointers wrap by natural overflow
    always_ff @(posedge Clk)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: ALU/load write-back arbiter with load pending scoreboard
// Define RFWB_FWD_EN for write-port forwarding and early pending clear.
import rv_pkg::*;
module rf_writeback #(
    parameter int dataWidth    = 32,
    parameter int numReg       = 32,
    parameter int AddressWidth = $clog2(numReg),
    parameter int FifoDepth    = 4
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [AddressWidth-1:0] alu_rd,
    input  logic [dataWidth-1:0]    alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [AddressWidth-1:0] mem_rd,
    input  logic [dataWidth-1:0]    mem_data,
    input  logic                    iss_valid,
    input  logic [AddressWidth-1:0] iss_rd,
    input  logic [AddressWidth-1:0] RegA,
    input  logic [AddressWidth-1:0] RegB,
    output logic                    busyA,
    output logic                    busyB,
    output logic                    RFwrite,
    output logic [AddressWidth-1:0] RegW,
    output logic [dataWidth-1:0]    dataW
`ifdef RFWB_FWD_EN
    ,
    output logic                    fwdA_valid,
    output logic [dataWidth-1:0]    fwdA_data,
    output logic                    fwdB_valid,
    output logic [dataWidth-1:0]    fwdB_data
`endif
);
    localparam int CW = $clog2(FifoDepth) + 1;
    wb_entry_t din, head;
    logic full, empty, push, pop;
    logic [CW-1:0] count;
    logic [numReg-1:0] pending, set_mask, clr_mask;
    // Ready depends only on the registered count, never on this cycle's pop
    assign mem_ready = !reset && count < CW'(FifoDepth);
    assign push      = mem_valid && mem_ready;
    assign pop       = !alu_valid && !empty;
    assign din       = '{rd: mem_rd, data: mem_data};
    rf_wb_fifo #(.FifoDepth(FifoDepth)) u_fifo (
        .Clk   (Clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge Clk)
        if (reset) begin
            RFwrite <= 1'b0;
            RegW    <= '0;
            dataW   <= '0;
        end else if (alu_valid) begin
            RFwrite <= alu_rd != '0;
            RegW    <= alu_rd;
            dataW   <= alu_data;
        end else if (pop) begin
            RFwrite <= head.rd != '0;
            RegW    <= head.rd;
            dataW   <= head.data;
        end else begin
            RFwrite <= 1'b0;
        end
    assign set_mask = (iss_valid && iss_rd != '0) ? numReg'(1) << iss_rd : '0;
`ifdef RFWB_FWD_EN
    // Forwarding covers the write cycle, so the bit can drop at the pop edge
    assign clr_mask   = pop ? numReg'(1) << head.rd : '0;
    assign fwdA_valid = RFwrite && RegW == RegA && RegA != '0;
    assign fwdB_valid = RFwrite && RegW == RegB && RegB != '0;
    assign fwdA_data  = dataW;
    assign fwdB_data  = dataW;
    assert property (@(posedge Clk) disable iff (reset)
        iss_valid && iss_rd != '0 |-> !pending[iss_rd]);
`else
    logic wb_load;
    always_ff @(posedge Clk)
        wb_load <= !reset && pop;
    assign clr_mask = (RFwrite && wb_load) ? numReg'(1) << RegW : '0;
`endif
    always_ff @(posedge Clk)
        pending <= reset ? '0 : (pending & ~clr_mask) | set_mask;
    assign busyA = pending[RegA];
    assign busyB = pending[RegB];
    assert property (@(posedge Clk) disable iff (reset) !(push && full));
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: scoreboard bench for rf_writeback
import rv_pkg::*;
module tb_rf_writeback;
    logic        Clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, mem_ready, iss_valid;
    logic [4:0]  alu_rd, mem_rd, iss_rd, RegA, RegB, RegW;
    logic [31:0] alu_data, mem_data, dataW;
    logic        busyA, busyB, RFwrite;
    int          n_chk = 0, n_pass = 0;
    wb_entry_t   mq[$];
    wb_entry_t   sb[$];
    logic        exp_wr;
    always #5 Clk = ~Clk;
    rf_writeback dut (
        .Clk       (Clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .RegA      (RegA),
        .RegB      (RegB),
        .busyA     (busyA),
        .busyB     (busyB),
        .RFwrite   (RFwrite),
        .RegW      (RegW),
        .dataW     (dataW)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    // Model one cycle of arbitration, advance the clock, then compare the write port
    task automatic tick();
        wb_entry_t e;
        logic acc;
        #1;
        acc = mem_valid && !reset && mq.size() < 4;
        check("mem_ready", mem_ready, !reset && mq.size() < 4);
        exp_wr = 1'b0;
        if (reset) begin
            mq.delete();
            sb.delete();
        end else begin
            if (alu_valid) begin
                if (alu_rd != 0) begin
                    sb.push_back('{rd: alu_rd, data: alu_data});
                    exp_wr = 1'b1;
                end
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.rd != 0) begin
                    sb.push_back(e);
                    exp_wr = 1'b1;
                end
            end
            if (acc) mq.push_back('{rd: mem_rd, data: mem_data});
        end
        @(posedge Clk);
        #1;
        check("RFwrite", RFwrite, exp_wr);
        if (exp_wr && sb.size() > 0) begin
            e = sb.pop_front();
            check("RegW", RegW, e.rd);
            check("dataW", dataW, e.data);
        end
    endtask
    task automatic idle();
        alu_valid = 0;
        mem_valid = 0;
        iss_valid = 0;
    endtask
    initial begin
        reset = 1; RegA = 7; RegB = 9;
        alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0; iss_rd = 0;
        idle();
        tick(); tick();
        check("rst_RegW", RegW, 0);
        check("rst_dataW", dataW, 0);
        check("rst_busyA", busyA, 0);
        reset = 0;
        tick();
        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        tick();
        check("alu_RFwrite", RFwrite, 1);
        check("alu_RegW", RegW, 5);
        check("alu_dataW", dataW, 32'h1234);
        idle();
        tick();
        check("alu_done", RFwrite, 0);
        // Load round trip: issue in cycle 1, return in cycle 4
        iss_valid = 1; iss_rd = 7;
        tick();
        check("busy_c2", busyA, 1);
        idle();
        tick(); tick();
        mem_valid = 1; mem_rd = 7; mem_data = 32'hDEADBEEF;
        tick();
        idle();
        check("busy_c5", busyA, 1);
        tick();
        check("load_RegW", RegW, 7);
`ifdef RFWB_FWD_EN
        check("busy_c6", busyA, 0);
`else
        check("busy_c6", busyA, 1);
`endif
        tick();
        check("busy_c7", busyA, 0);
        // rd=0 from ALU, load and issue
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        tick();
        alu_valid = 0; mem_valid = 1; mem_rd = 0; mem_data = 32'h66;
        tick();
        mem_valid = 1; mem_rd = 2; mem_data = 32'h77;
        tick();
        idle();
        iss_valid = 1; iss_rd = 0; RegA = 0;
        tick();
        idle();
        check("busy_r0", busyA, 0);
        tick(); tick();
        // Contention: FIFO holds rd=4 while ALU writes rd=3
        mem_valid = 1; mem_rd = 4; mem_data = 32'h4444;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1111;
        tick();
        mem_valid = 0; alu_rd = 3; alu_data = 32'h3333;
        tick();
        idle();
        tick(); tick();
        // Fill the FIFO behind continuous ALU writes
        alu_valid = 1;
        for (int i = 0; i < 4; i++) begin
            alu_rd = 5'(20 + i); alu_data = 32'hA000 + i;
            mem_valid = 1; mem_rd = 5'(10 + i); mem_data = 32'hB000 + i;
            tick();
        end
        mem_valid = 0;
        check("full_ready", mem_ready, 0);
        tick();
        alu_valid = 0;
        for (int i = 0; i < 6; i++) tick();
        // Reset mid-drain with three loads buffered and a pending bit set
        iss_valid = 1; iss_rd = 9;
        tick();
        iss_valid = 0;
        check("busyB_set", busyB, 1);
        alu_valid = 1; alu_rd = 6; alu_data = 32'hC0;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1; mem_rd = 5'(12 + i); mem_data = 32'hD000 + i;
            tick();
        end
        idle();
        reset = 1;
        tick();
        check("rst_busyB", busyB, 0);
        reset = 0;
        for (int i = 0; i < 5; i++) tick();
        // Random traffic
        for (int i = 0; i < 300; i++) begin
            alu_valid = $urandom_range(0, 2) == 0;
            alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
            mem_valid = $urandom_range(0, 1) == 1;
            mem_rd = 5'($urandom_range(0, 31)); mem_data = $urandom;
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) tick();
        check("drained_fifo", mq.size(), 0);
        check("drained_sb", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-back arbiter and load scoreboard feeding the processor's single register-file write port. Single-cycle ALU results take priority. Multi-cycle load returns are buffered in a small FIFO and drained into the write port on cycles with no ALU write. A per-register pending bitmap tells decode which source registers still await a load, so decode can stall. The registered outputs drive the register file's `RFwrite`/`RegW`/`dataW` inputs directly.

## Interface
Parameters:
- `dataWidth`, default 32: register data width.
- `numReg`, default 32: number of architectural registers.
- `AddressWidth`, default `$clog2(numReg)`: register index width.
- `FifoDepth`, default 4: load-return buffer entries, power of two, ≥2.

Ports:
- `Clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `alu_valid`  in  1  ALU result present this cycle; always accepted.
- `alu_rd`  in  AddressWidth  ALU destination.
- `alu_data`  in  dataWidth  ALU result.
- `mem_valid`  in  1  load return present.
- `mem_ready`  out  1  FIFO can accept a load return.
- `mem_rd`  in  AddressWidth  load destination.
- `mem_data`  in  dataWidth  load data.
- `iss_valid`  in  1  a load is issued this cycle.
- `iss_rd`  in  AddressWidth  destination of the issued load.
- `RegA`, `RegB`  in  AddressWidth  decode source indices.
- `busyA`, `busyB`  out  1  source has a pending load (combinational from pending bitmap).
- `RFwrite`  out  1  register-file write enable (registered).
- `RegW`  out  AddressWidth  write index (registered).
- `dataW`  out  dataWidth  write data (registered).

## Operation
- Reset values:
  - `RFwrite`=0, `RegW`=0, `dataW`=0.
  - FIFO empty, count=0, pending bitmap all 0.
  - `mem_ready`=0 while `reset` is high.
- Load handshake:
  - A load return is accepted when `mem_valid && mem_ready`.
  - Accepted returns are pushed as {rd, data}.
  - `mem_ready` = (count < FifoDepth), derived from registered count only. It has no combinational path from `alu_valid` or the pop decision.
- Per-cycle selection, in priority order:
  1. `alu_valid`: load the ALU result into the output registers.
  2. Otherwise, FIFO non-empty: pop the head and load it into the output registers.
  3. Otherwise: `RFwrite`=0 next cycle.
- rd=0: the entry is still consumed (popped or accepted), but `RFwrite` is held at 0 for it. Register 0 is never written.
- Push and pop in the same cycle: count is unchanged; pointers wrap modulo FifoDepth.
- Pending bitmap:
  - Set bit `iss_rd` when `iss_valid` and `iss_rd`≠0.
  - Clear bit rd when that load's write completes (see Timing).
  - If a set and a clear hit the same register on the same edge, the set wins.
- Issue contract: decode does not issue a load to a register whose pending bit is set. Under `RFWB_FWD_EN` a violation fires an assertion.
- ALU results never touch the pending bitmap.
- No state machine beyond the FIFO pointers/count and the output registers.

## Timing
- ALU result valid in cycle N → `RFwrite`/`RegW`/`dataW` high/valid in cycle N+1. The register file commits at the end of N+1.
- Load accepted in cycle N:
  - Pushed at the end of N.
  - Earliest pop is in cycle N+1 (if no ALU result) → `RFwrite` in N+2.
- Each ALU cycle delays the FIFO drain by one cycle. Loads may starve indefinitely under continuous ALU writes. Upstream is throttled by `mem_ready`.
- Pending clear (macro off): the bit clears on the edge ending the `RFwrite` cycle (end of N+2). `busy` is first low in N+3, when a register-file read returns the new value.
- Reset asserted mid-operation: all buffered loads are discarded and any in-flight write is cancelled (`RFwrite`=0 next cycle).

## Configuration
- `RFWB_FWD_EN` defined:
  - Adds outputs `fwdA_valid`, `fwdA_data`, `fwdB_valid`, `fwdB_data`.
  - `fwdX_valid` = `RFwrite && RegW==RegX && RegX!=0`.
  - `fwdX_data` = `dataW`.
  - The pending bit clears at the pop edge, so `busy` drops one cycle earlier (first low in N+2, covered by forwarding).
  - Enables the issue-contract assertion.
- `RFWB_FWD_EN` undefined:
  - The forwarding ports and the assertion are absent.
  - Clear timing is as in Timing.

## Structure
- Shared package `rv_pkg` holds:
  - Constants `DATA_W`=32 and `REG_ADDR_W`=5.
  - Typedef `wb_entry_t` (packed struct {rd, data}).
- Sub-module `rf_wb_fifo` holds:
  - A synchronous FIFO of `wb_entry_t` with `FifoDepth` entries.
  - Ports: push/pop/full/empty/count and a head output.
- `rf_writeback` holds the arbitration, output registers, and pending bitmap.

## Test plan
- ALU only: `alu_valid`, rd=5, data=0x1234 in cycle 3 → cycle 4 `RFwrite`=1, `RegW`=5, `dataW`=0x1234; cycle 5 `RFwrite`=0.
- Load round trip:
  - Stimulus: issue rd=7 in cycle 1; `mem_valid` rd=7, data=0xDEADBEEF in cycle 4.
  - `busyA`(RegA=7)=1 from cycle 2.
  - Cycle 6: `RFwrite` with `RegW`=7.
  - `busyA`=0 in cycle 7 (macro off) or cycle 6 (macro on).
- Contention: ALU rd=3 and FIFO holding rd=4 in the same cycle → ALU write first, rd=4 written the next cycle, count decrements by 1.
- Full FIFO:
  - Stimulus: push 4 loads while `alu_valid` is held high.
  - `mem_ready`=0 after the 4th acceptance.
  - Deassert `alu_valid` → writes occur in FIFO order over the following 4 cycles.
  - `mem_ready` rises one cycle after the first pop.
- rd=0: ALU or load with rd=0 → `RFwrite` stays 0, FIFO count still decrements; `iss_rd`=0 sets no pending bit.
- Reset mid-drain: `reset` with 3 entries buffered → next cycle `RFwrite`=0, `mem_ready`=0 during reset, all `busy`=0, no stale writes after reset is released.
